// File: rtl/trace_drain_pkg.sv
// Shared types and constants for the trace drain: record layout, marker tag, serializer states.
package trace_drain_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [7:0]  event_code;
   } trace_output;

   localparam int unsigned TRACE_W          = $bits(trace_output);
   localparam logic [15:0] TRACE_MARKER_TAG = 16'hDEAD;

   typedef enum logic {
      IDLE,
      SEND
   } trace_drain_state;

   // Words per frame for a given stream width (last word zero-padded).
   function automatic int unsigned trace_nwords(input int unsigned out_width);
      return (TRACE_W + out_width - 1) / out_width;
   endfunction

endpackage

// File: rtl/trace_drain_if.sv
// Trace capture strobe plus valid/ready stream toward the debug host link.
interface trace_drain_if
   import trace_drain_pkg::*;
#(
   parameter int unsigned OUT_WIDTH = 32
);
   logic                 trace_data_ready;
   trace_output          trace_data_i;
   logic                 tx_valid;
   logic [OUT_WIDTH-1:0] tx_data;
   logic                 tx_last;
   logic                 tx_ready;

   modport master (
      input  trace_data_ready, trace_data_i, tx_ready,
      output tx_valid, tx_data, tx_last
   );

   modport slave (
      output trace_data_ready, trace_data_i, tx_ready,
      input  tx_valid, tx_data, tx_last
   );
endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO; a push while full is still accepted when a pop happens in the same cycle.
module trace_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter type         T     = logic [7:0]
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  T                           wdata,
   output T                           head,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH + 1);

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && !flush && (!full || pop_ok);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(push_ok) - LW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/trace_drain.sv
// Queues trace records and serialises each into NWORDS stream words, LSB word first.
// Optional TRACE_DRAIN_OVERFLOW_MARK_EN: emit a 0xDEAD marker frame after dropped records.
module trace_drain
   import trace_drain_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned OUT_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   trace_drain_if.master              bus,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic [15:0]                overflow_count
);
   localparam int unsigned   NWORDS   = trace_nwords(OUT_WIDTH);
   localparam int unsigned   FRAME_W  = NWORDS * OUT_WIDTH;
   localparam int unsigned   IW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

   trace_drain_state   state, state_n;
   logic [IW-1:0]      word_idx, word_idx_n;
   logic [FRAME_W-1:0] frame, frame_n;
   trace_output        head;
   logic               full, empty, pop, accept, last_acc, drop;

   trace_fifo #(
      .DEPTH (DEPTH),
      .T     (trace_output)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (bus.trace_data_ready),
      .pop   (pop),
      .wdata (bus.trace_data_i),
      .head  (head),
      .level (fifo_level),
      .full  (full),
      .empty (empty)
   );

   assign accept   = (state == SEND) && bus.tx_ready;
   assign last_acc = accept && (word_idx == LAST_IDX);
   assign drop     = bus.trace_data_ready && !flush && full && !pop;

`ifdef TRACE_DRAIN_OVERFLOW_MARK_EN
   logic [15:0]          since_mark;
   logic                 is_marker, is_marker_n, mark_pending;
   logic [OUT_WIDTH-1:0] marker_word;

   // The marker being retired must not re-trigger itself from its own stale count.
   assign mark_pending = (since_mark != '0) && !(last_acc && is_marker);

   always_comb begin
      marker_word                    = '0;
      marker_word[15:0]              = since_mark;
      marker_word[OUT_WIDTH-1 -: 16] = TRACE_MARKER_TAG;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         since_mark <= '0;
         is_marker  <= 1'b0;
      end else begin
         is_marker <= is_marker_n;
         if (last_acc && is_marker)
            since_mark <= {15'd0, drop};
         else if (drop && since_mark != '1)
            since_mark <= since_mark + 16'd1;
      end
   end
`endif

   always_comb begin
      state_n    = state;
      word_idx_n = word_idx;
      frame_n    = frame;
      pop        = 1'b0;
`ifdef TRACE_DRAIN_OVERFLOW_MARK_EN
      is_marker_n = is_marker;
`endif
      if (accept) begin
         frame_n    = frame >> OUT_WIDTH;
         word_idx_n = word_idx + 1'b1;
      end
      // Frame boundary: pick the next frame in the same cycle so frames run back-to-back.
      if ((state == IDLE) || last_acc) begin
         state_n    = IDLE;
         word_idx_n = '0;
`ifdef TRACE_DRAIN_OVERFLOW_MARK_EN
         if (mark_pending) begin
            state_n                  = SEND;
            frame_n                  = '0;
            frame_n[OUT_WIDTH-1:0]   = marker_word;
            word_idx_n               = LAST_IDX;
            is_marker_n              = 1'b1;
         end else
`endif
         if (!empty) begin
            state_n                = SEND;
            pop                    = 1'b1;
            frame_n                = '0;
            frame_n[TRACE_W-1:0]   = head;
`ifdef TRACE_DRAIN_OVERFLOW_MARK_EN
            is_marker_n            = 1'b0;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         word_idx       <= '0;
         frame          <= '0;
         overflow_count <= '0;
      end else begin
         state    <= state_n;
         word_idx <= word_idx_n;
         frame    <= frame_n;
         if (drop && overflow_count != '1)
            overflow_count <= overflow_count + 16'd1;
      end
   end

   assign bus.tx_valid = (state == SEND);
   assign bus.tx_data  = frame[OUT_WIDTH-1:0];
   assign bus.tx_last  = (state == SEND) && (word_idx == LAST_IDX);
endmodule

// File: tb/tb_trace_drain.sv
// Self-checking bench for trace_drain: hand-computed word tables, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_trace_drain;
   import trace_drain_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned OW    = 32;
   localparam int unsigned NW    = trace_nwords(OW);
   localparam int unsigned LW    = $clog2(DEPTH + 1);
`ifdef TRACE_DRAIN_OVERFLOW_MARK_EN
   localparam bit MARK = 1'b1;
`else
   localparam bit MARK = 1'b0;
`endif

   typedef logic [OW-1:0] word_t;
   typedef struct {
      trace_output rec;
      word_t       w [3];
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [LW-1:0] fifo_level;
   logic [15:0]   overflow_count;

   trace_drain_if #(.OUT_WIDTH(OW)) bus ();

   trace_drain #(
      .DEPTH     (DEPTH),
      .OUT_WIDTH (OW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .flush          (flush),
      .fifo_level     (fifo_level),
      .overflow_count (overflow_count)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned passed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: record queue, words of the frame on the wire, drop counters.
   trace_output mq  [$];
   word_t       cur [$];
   bit          cur_mark;
   int unsigned m_ovf, m_since;

   function automatic void load_rec(input trace_output r);
      logic [NW*OW-1:0] f;
      f = '0;
      f[TRACE_W-1:0] = r;
      cur.delete();
      for (int k = 0; k < NW; k++) cur.push_back(f[k*OW +: OW]);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         cur.delete();
         cur_mark = 1'b0;
         m_ovf    = 0;
         m_since  = 0;
      end else begin : m_step
         bit acc, fend, pend;
         acc  = (cur.size() > 0) && bus.tx_ready;
         fend = acc && (cur.size() == 1);
         if (acc) void'(cur.pop_front());
         pend = (m_since > 0) && !(fend && cur_mark);
         if (fend && cur_mark) m_since = 0;
         if (cur.size() == 0) begin
            if (MARK && pend) begin
               cur.push_back({16'hDEAD, 16'(m_since)});
               cur_mark = 1'b1;
            end else if (mq.size() > 0) begin
               load_rec(mq.pop_front());
               cur_mark = 1'b0;
            end
         end
         if (bus.trace_data_ready && !flush) begin
            if (mq.size() < DEPTH) mq.push_back(bus.trace_data_i);
            else begin
               if (m_ovf < 65535) m_ovf++;
               if (m_since < 65535) m_since++;
            end
         end
         if (flush) mq.delete();
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("model_valid", bus.tx_valid, cur.size() > 0);
         if (cur.size() > 0) begin
            chk("model_data", bus.tx_data, cur[0]);
            chk("model_last", bus.tx_last, cur.size() == 1);
         end
         chk("model_level", fifo_level, mq.size());
         chk("model_ovf", overflow_count, m_ovf);
      end
   end

   vec_t tbl [4];

   task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] ins,
                          input logic [7:0] ev, input word_t w0, input word_t w1, input word_t w2);
      tbl[i].rec  = trace_output'({a, ins, ev});
      tbl[i].w[0] = w0;
      tbl[i].w[1] = w1;
      tbl[i].w[2] = w2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.trace_data_ready = 1'b0;
      bus.tx_ready = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("rst_valid", bus.tx_valid, 1'b0);
      chk("rst_last", bus.tx_last, 1'b0);
      chk("rst_data", bus.tx_data, '0);
      chk("rst_level", fifo_level, '0);
      chk("rst_ovf", overflow_count, '0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic strobe_burst(input int n, input bit ready);
      bus.tx_ready = ready;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.trace_data_ready = 1'b1;
         bus.trace_data_i = trace_output'({32'(i), 32'h1300_0000 + 32'(i), 8'(i)});
      end
      @(negedge clk);
      bus.trace_data_ready = 1'b0;
   endtask

   initial begin
      int    frames, gaps, mpos, wi;
      bit    done, seen;
      word_t fw [3];

      rst = 1'b1;
      flush = 1'b0;
      bus.trace_data_ready = 1'b0;
      bus.trace_data_i = '0;
      bus.tx_ready = 1'b0;

      set_vec(0, 32'h0000_0080, 32'h00A0_0093, 8'h5A, 32'hA000_935A, 32'h0000_8000, 32'h0000_0000);
      set_vec(1, 32'h1234_5678, 32'h9ABC_DEF0, 8'hC3, 32'hBCDE_F0C3, 32'h3456_789A, 32'h0000_0012);
      set_vec(2, 32'hFFFF_FFFF, 32'h0000_0000, 8'hFF, 32'h0000_00FF, 32'hFFFF_FF00, 32'h0000_00FF);
      set_vec(3, 32'h0000_0000, 32'hFFFF_FFFF, 8'h00, 32'hFFFF_FF00, 32'h0000_00FF, 32'h0000_0000);

      do_reset();

      // Single records: latency, word order, tx_last placement.
      for (int i = 0; i < 4; i++) begin
         bus.tx_ready = 1'b1;
         @(negedge clk);
         bus.trace_data_ready = 1'b1;
         bus.trace_data_i = tbl[i].rec;
         @(negedge clk);
         bus.trace_data_ready = 1'b0;
         chk("s1_valid_lat", bus.tx_valid, 1'b0);
         for (int k = 0; k < NW; k++) begin
            @(negedge clk);
            chk("s1_valid", bus.tx_valid, 1'b1);
            chk("s1_word", bus.tx_data, tbl[i].w[k]);
            chk("s1_last", bus.tx_last, k == NW - 1);
         end
         @(negedge clk);
         chk("s1_end_valid", bus.tx_valid, 1'b0);
         chk("s1_end_level", fifo_level, '0);
      end

      // Backpressure mid-frame.
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.trace_data_ready = 1'b1;
      bus.trace_data_i = tbl[1].rec;
      @(negedge clk);
      bus.trace_data_ready = 1'b0;
      @(negedge clk);
      chk("s2_w0", bus.tx_data, tbl[1].w[0]);
      @(negedge clk);
      chk("s2_w1", bus.tx_data, tbl[1].w[1]);
      bus.tx_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("s2_hold_valid", bus.tx_valid, 1'b1);
         chk("s2_hold_data", bus.tx_data, tbl[1].w[1]);
         chk("s2_hold_last", bus.tx_last, 1'b0);
      end
      bus.tx_ready = 1'b1;
      @(negedge clk);
      chk("s2_w2", bus.tx_data, tbl[1].w[2]);
      chk("s2_w2_last", bus.tx_last, 1'b1);
      @(negedge clk);
      chk("s2_end_valid", bus.tx_valid, 1'b0);

      // Overflow: one record enters the serializer, DEPTH queue, 3 dropped.
      do_reset();
      strobe_burst(DEPTH + 4, 1'b0);
      chk("s3_level_full", fifo_level, DEPTH);
      chk("s3_ovf", overflow_count, 3);
      frames = 0; gaps = 0; mpos = -1; wi = 0; done = 1'b0;
      bus.tx_ready = 1'b1;
      for (int c = 0; c < 400 && !done; c++) begin
         if (bus.tx_valid) begin
`ifdef TRACE_DRAIN_OVERFLOW_MARK_EN
            if (wi == 0 && bus.tx_last) begin
               chk("s4_marker_word", bus.tx_data, 32'hDEAD_0003);
               mpos = frames;
            end else
`endif
            begin
               fw[wi] = bus.tx_data;
               if (bus.tx_last) begin
                  chk("s3_order", {fw[2][7:0], fw[1][31:8]}, frames);
                  frames++;
                  wi = 0;
               end else wi++;
            end
         end else if (frames == DEPTH + 1) done = 1'b1;
         else gaps++;
         @(negedge clk);
      end
      chk("s3_drained", done, 1'b1);
      chk("s3_frames", frames, DEPTH + 1);
      chk("s3_gaps", gaps, 0);
`ifdef TRACE_DRAIN_OVERFLOW_MARK_EN
      chk("s4_marker_pos", mpos, 1);
`endif
      bus.trace_data_ready = 1'b1;
      bus.trace_data_i = tbl[2].rec;
      @(negedge clk);
      bus.trace_data_ready = 1'b0;
      repeat (NW + 4) @(negedge clk);
      chk("s3_ovf_kept", overflow_count, 3);

      // Flush mid-frame with 4 records queued.
      do_reset();
      strobe_burst(5, 1'b0);
      chk("s5_level", fifo_level, 4);
      bus.tx_ready = 1'b1;
      @(negedge clk);
      flush = 1'b1;
      bus.trace_data_ready = 1'b1;
      bus.trace_data_i = tbl[3].rec;
      @(negedge clk);
      flush = 1'b0;
      bus.trace_data_ready = 1'b0;
      chk("s5_level_clr", fifo_level, '0);
      chk("s5_ovf", overflow_count, '0);
      chk("s5_last_word", bus.tx_last, 1'b1);
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.tx_valid) seen = 1'b1;
      end
      chk("s5_no_more_frames", seen, 1'b0);

      // Async reset mid-frame.
      strobe_burst(DEPTH + 3, 1'b0);
      chk("s6_pre_valid", bus.tx_valid, 1'b1);
      chk("s6_pre_ovf", overflow_count, 2);
      #2 rst = 1'b1;
      #1;
      chk("s6_valid", bus.tx_valid, 1'b0);
      chk("s6_last", bus.tx_last, 1'b0);
      chk("s6_level", fifo_level, '0);
      chk("s6_ovf", overflow_count, '0);
      @(negedge clk);
      rst = 1'b0;
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.trace_data_ready = 1'b1;
      bus.trace_data_i = tbl[0].rec;
      @(negedge clk);
      bus.trace_data_ready = 1'b0;
      @(negedge clk);
      chk("s6_restart_valid", bus.tx_valid, 1'b1);
      chk("s6_restart_w0", bus.tx_data, tbl[0].w[0]);
      repeat (NW + 2) @(negedge clk);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         bus.tx_ready = ($urandom_range(0, 99) < 60);
         bus.trace_data_ready = ($urandom_range(0, 99) < 35);
         bus.trace_data_i = trace_output'({$urandom(), $urandom(), 8'($urandom())});
         flush = ($urandom_range(0, 99) < 2);
      end
      @(negedge clk);
      bus.trace_data_ready = 1'b0;
      flush = 1'b0;
      bus.tx_ready = 1'b1;
      repeat ((DEPTH + 2) * (NW + 1) + 10) @(negedge clk);
      chk("rand_drained_valid", bus.tx_valid, 1'b0);
      chk("rand_drained_level", fifo_level, '0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
